// File: rtl/unary_add_multi.sv
// Multi-channel unary accumulator: sums popcount(din) into a wrapping or
// saturating counter, then replays the count as a unary dout pulse train.
module unary_add_multi #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 6,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             read_or_write,
  input  logic [N_CH-1:0]  din,
  input  logic             clr,
  output logic             dout,
  output logic             C,
  output logic             done,
  output logic [CNT_W-1:0] count_o
);

  localparam int SUM_W = CNT_W + $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RD  = 2'd1,
    ST_FIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               c_q, c_d;
  logic               dout_q, dout_d;
  logic               done_q, done_d;
  logic [SUM_W-1:0]   sum;

  // State register: every output is a flop, so nothing on the ports
  // depends combinationally on an input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_ACC;
      count_q  <= '0;
      rd_cnt_q <= '0;
      c_q      <= 1'b0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_cnt_q <= rd_cnt_d;
      c_q      <= c_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; en=0 holds the current state.
  always_comb begin
    // NOTE: default-assign before the case so no path leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        ST_ACC:  if (!clr && read_or_write) state_d = ST_RD;
        ST_RD: begin
          if (!read_or_write)       state_d = ST_ACC;
          else if (rd_cnt_q == '0)  state_d = ST_FIN;
        end
        ST_FIN:  if (!read_or_write) state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Full-width sum: popcount added without truncation so overflow is exact.
  always_comb begin
    sum = SUM_W'(count_q);
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + SUM_W'(din[i]);
    end
  end

  // Datapath and registered output decode.
  always_comb begin
    count_d  = count_q;
    rd_cnt_d = rd_cnt_q;
    c_d      = c_q;
    dout_d   = 1'b0;
    done_d   = 1'b0;
    if (en) begin
      unique case (state_q)
        ST_ACC: begin
          if (clr) begin
            count_d = '0;
            c_d     = 1'b0;
          end else if (read_or_write) begin
            rd_cnt_d = count_q;
          end else if (sum[SUM_W-1:CNT_W] != '0) begin
            c_d     = 1'b1;
            count_d = (SAT_MODE != 0) ? CNT_MAX : sum[CNT_W-1:0];
          end else begin
            count_d = sum[CNT_W-1:0];
          end
        end
        ST_RD: begin
          if (read_or_write) begin
            if (rd_cnt_q != '0) begin
              rd_cnt_d = rd_cnt_q - CNT_W'(1);
              dout_d   = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_FIN: begin
          if (!read_or_write) begin
            count_d = '0;
            c_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout    = dout_q;
  assign done    = done_q;
  assign C       = c_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_unary_add_multi.sv
// Scoreboard bench for unary_add_multi: three configurations (wrap, saturate,
// 4-channel/4-bit) share stimulus and are checked against a behavioural model.
module tb_unary_add_multi;

  logic       clk;
  logic       rst, en, rw, clr;
  logic [3:0] din;

  logic       dout0, dout1, dout2;
  logic       c0, c1, c2;
  logic       done0, done1, done2;
  logic [5:0] cnt0, cnt1;
  logic [3:0] cnt2;

  unary_add_multi #(.N_CH(2), .CNT_W(6), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din[1:0]),
    .clr(clr), .dout(dout0), .C(c0), .done(done0), .count_o(cnt0));

  unary_add_multi #(.N_CH(2), .CNT_W(6), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din[1:0]),
    .clr(clr), .dout(dout1), .C(c1), .done(done1), .count_o(cnt1));

  unary_add_multi #(.N_CH(4), .CNT_W(4), .SAT_MODE(0)) u_quad (
    .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din),
    .clr(clr), .dout(dout2), .C(c2), .done(done2), .count_o(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       dout;
    logic [2:0]       done;
    logic [2:0]       c;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: phase 0 = accumulating, 1 = replaying, 2 = finished.
  localparam int NCH [3] = '{2, 2, 4};
  localparam int WID [3] = '{6, 6, 4};
  localparam int SAT [3] = '{0, 1, 0};
  int m_ph [3];
  int m_cnt[3];
  int m_rem[3];
  int m_c  [3];

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_step(input logic e, input logic r_w, input logic cl,
                            input logic [3:0] d, input logic r);
    exp_t x;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      int lim, pop;
      lim = 1 << WID[i];
      pop = (NCH[i] == 4) ? $countones(d) : $countones(d[1:0]);
      if (r) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_rem[i] = 0; m_c[i] = 0;
      end else if (e) begin
        case (m_ph[i])
          0: begin
            if (cl) begin
              m_cnt[i] = 0; m_c[i] = 0;
            end else if (r_w) begin
              m_ph[i] = 1; m_rem[i] = m_cnt[i];
            end else if (m_cnt[i] + pop >= lim) begin
              m_c[i]   = 1;
              m_cnt[i] = (SAT[i] != 0) ? lim - 1 : (m_cnt[i] + pop) % lim;
            end else begin
              m_cnt[i] = m_cnt[i] + pop;
            end
          end
          1: begin
            if (!r_w) m_ph[i] = 0;
            else if (m_rem[i] > 0) begin
              m_rem[i]--; x.dout[i] = 1'b1;
            end else begin
              x.done[i] = 1'b1; m_ph[i] = 2;
            end
          end
          default: begin
            if (!r_w) begin
              m_ph[i] = 0; m_cnt[i] = 0; m_c[i] = 0;
            end
          end
        endcase
      end
      x.c[i]   = m_c[i][0];
      x.cnt[i] = 16'(m_cnt[i]);
    end
    sb.push_back(x);
  endtask

  // One clock: drive inputs, let the edge happen, then record the expectation.
  task automatic cyc(input logic e, input logic r_w, input logic cl,
                     input logic [3:0] d, input logic r);
    en = e; rw = r_w; clr = cl; din = d; rst = r;
    @(posedge clk);
    #1;
    model_step(e, r_w, cl, d, r);
  endtask

  // Monitor: compares every registered output against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("dout_wrap", int'(dout0), int'(e.dout[0]));
      check("dout_sat",  int'(dout1), int'(e.dout[1]));
      check("dout_quad", int'(dout2), int'(e.dout[2]));
      check("done_wrap", int'(done0), int'(e.done[0]));
      check("done_sat",  int'(done1), int'(e.done[1]));
      check("done_quad", int'(done2), int'(e.done[2]));
      check("c_wrap",    int'(c0),    int'(e.c[0]));
      check("c_sat",     int'(c1),    int'(e.c[1]));
      check("c_quad",    int'(c2),    int'(e.c[2]));
      check("cnt_wrap",  int'(cnt0),  int'(e.cnt[0]));
      check("cnt_sat",   int'(cnt1),  int'(e.cnt[1]));
      check("cnt_quad",  int'(cnt2),  int'(e.cnt[2]));
    end
  end

  int  pulses, bad, done_at;
  logic rw_hold;

  initial begin
    en = 0; rw = 0; clr = 0; din = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 0; m_cnt[i] = 0; m_rem[i] = 0; m_c[i] = 0;
    end

    // Reset state.
    cyc(1, 1, 1, 4'hF, 1);
    check("rst_cnt", int'(cnt0), 0);
    check("rst_c", int'(c0), 0);
    check("rst_dout_done", int'(dout0 | done0), 0);

    // Wrap vs saturate: 66 units into a 6-bit counter.
    for (int k = 0; k < 33; k++) cyc(1, 0, 0, 4'b0011, 0);
    for (int k = 0; k < 33; k++) cyc(1, 0, 0, 4'b0000, 0);
    check("wrap_cnt", int'(cnt0), 2);
    check("wrap_c", int'(c0), 1);
    check("sat_cnt", int'(cnt1), 63);
    check("sat_c", int'(c1), 1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 4'b0001, 0);
    check("sat_hold", int'(cnt1), 63);
    cyc(1, 0, 1, 4'b0011, 0);
    check("clr_cnt", int'(cnt0), 0);
    check("clr_c", int'(c0), 0);

    // Four-channel wrap to exactly 2^4, then clr beats accumulation.
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 4'b1111, 0);
    check("quad_cnt", int'(cnt2), 0);
    check("quad_c", int'(c2), 1);
    cyc(1, 0, 1, 4'b1011, 0);
    check("quad_clr_cnt", int'(cnt2), 0);
    check("quad_clr_c", int'(c2), 0);

    // Accumulate 5 and read it out.
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 0, 0, 4'b0001, 0);
    cyc(1, 1, 0, 4'b1111, 0);
    pulses = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 1, 0, 4'b0000, 0);
      pulses += int'(dout0);
      if (done0) begin done_at = k; break; end
    end
    check("rd5_pulses", pulses, 5);
    check("rd5_done_at", done_at, 6);
    check("rd5_cnt", int'(cnt0), 5);
    cyc(1, 1, 0, 4'b0000, 0);
    check("fin_quiet", int'(dout0 | done0), 0);
    check("fin_cnt", int'(cnt0), 5);
    cyc(1, 0, 0, 4'b0011, 0);
    check("fin_exit_cnt", int'(cnt0), 0);

    // Zero-length readout: done on the first RD cycle.
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    check("rd0_done", int'(done0), 1);
    check("rd0_dout", int'(dout0), 0);
    cyc(1, 0, 0, 4'b0000, 0);

    // Readout of 4 with en low for three cycles in the middle.
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    pulses = 0; bad = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      logic e;
      e = !(k >= 2 && k <= 4);
      cyc(e, 1, 0, 4'b0000, 0);
      if (dout0) begin
        pulses++;
        if (!e) bad++;
      end
      if (done0) begin done_at = k; break; end
    end
    check("pause_pulses", pulses, 4);
    check("pause_bad", bad, 0);
    check("pause_done_at", done_at, 8);
    cyc(1, 0, 0, 4'b0000, 0);

    // Reset during the third readout cycle.
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 1);
    check("midrst_outs", int'(dout0 | done0 | c0), 0);
    check("midrst_cnt", int'(cnt0), 0);

    // Abort mid-readout, then restart the readout from scratch.
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 0, 0, 4'b0011, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 1, 0, 4'b0000, 0);
    cyc(1, 0, 0, 4'b0000, 0);
    check("abort_cnt", int'(cnt0), 4);
    check("abort_outs", int'(dout0 | done0), 0);
    cyc(1, 1, 0, 4'b0000, 0);
    pulses = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 1, 0, 4'b0000, 0);
      pulses += int'(dout0);
      if (done0) begin done_at = k; break; end
    end
    check("restart_pulses", pulses, 4);
    check("restart_done_at", done_at, 5);
    cyc(1, 0, 0, 4'b0000, 0);

    // Randomised traffic with run-length biased read_or_write.
    rw_hold = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 8) rw_hold = ~rw_hold;
      cyc($urandom_range(0, 99) < 80, rw_hold, $urandom_range(0, 99) < 4,
          4'($urandom), $urandom_range(0, 499) == 0);
    end

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
